// File: rtl/regfile_loader_pkg.sv
// Shared state encoding and parameter defaults for the register-file loader.
// REGFILE_LOADER_VERIFY_EN adds the CHECK state used by the read-back verify path.
package regfile_loader_pkg;

  localparam int unsigned DATA_W_DEF     = 8;
  localparam int unsigned ADDR_W_DEF     = 4;
  localparam int unsigned FIRST_ADDR_DEF = 1;
  localparam int unsigned LAST_ADDR_DEF  = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FINISH = 2'd2
`ifdef REGFILE_LOADER_VERIFY_EN
    , ST_CHECK = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/loader_addr_counter.sv
// Write-address counter: loads FIRST_ADDR, increments per accepted word and
// saturates at LAST_ADDR so it can never run past the end or wrap to 0.
module loader_addr_counter #(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned FIRST_ADDR = 1,
  parameter int unsigned LAST_ADDR  = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LAST_ADDR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      addr <= FIRST;
    else if (load)
      addr <= FIRST;
    else if (inc && (addr != LAST))
      addr <= addr + ADDR_W'(1);
  end

endmodule

// File: rtl/regfile_loader.sv
// Streams words from a valid/ready source into register-file write port 3.
// Optional macro REGFILE_LOADER_VERIFY_EN adds read-back checking (RA_chk/RD_chk/err).
module regfile_loader
  import regfile_loader_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned FIRST_ADDR = FIRST_ADDR_DEF,
  parameter int unsigned LAST_ADDR  = LAST_ADDR_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              we3,
  output logic [ADDR_W-1:0] WA3,
  output logic [DATA_W-1:0] WD3
`ifdef REGFILE_LOADER_VERIFY_EN
  ,
  output logic [ADDR_W-1:0] RA_chk,
  input  logic [DATA_W-1:0] RD_chk,
  output logic              err
`endif
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr;
  logic              accept;
  logic              start_acc;
  logic              at_last;

  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FINISH);
  assign accept    = in_valid & in_ready;
  assign start_acc = (state_q == ST_IDLE) & start;
  assign at_last   = (addr == ADDR_W'(LAST_ADDR));

  loader_addr_counter #(
    .ADDR_W     (ADDR_W),
    .FIRST_ADDR (FIRST_ADDR),
    .LAST_ADDR  (LAST_ADDR)
  ) u_addr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (start_acc),
    .inc     (accept),
    .addr    (addr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_LOAD;
`ifdef REGFILE_LOADER_VERIFY_EN
      ST_LOAD:   if (accept && at_last) state_d = ST_CHECK;
      ST_CHECK:  state_d = ST_FINISH;
`else
      ST_LOAD:   if (accept && at_last) state_d = ST_FINISH;
`endif
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Write port is registered: the word accepted this cycle is written next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we3 <= 1'b0;
      WA3 <= '0;
      WD3 <= '0;
    end else begin
      we3 <= accept;
      if (accept) begin
        WA3 <= addr;
        WD3 <= in_data;
      end
    end
  end

`ifdef REGFILE_LOADER_VERIFY_EN
  logic              chk_v;
  logic [DATA_W-1:0] chk_data;
  logic              err_q;
  logic              mismatch;

  // Keep a private copy of the last write so back-to-back writes don't disturb the check.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chk_v    <= 1'b0;
      RA_chk   <= '0;
      chk_data <= '0;
      err_q    <= 1'b0;
    end else begin
      chk_v    <= we3;
      RA_chk   <= WA3;
      chk_data <= WD3;
      if (start_acc)     err_q <= 1'b0;
      else if (mismatch) err_q <= 1'b1;
    end
  end

  assign mismatch = chk_v & (RD_chk != chk_data);
  assign err      = err_q | mismatch;
`endif

endmodule

// File: tb/tb_regfile_loader.sv
// Scoreboard bench for regfile_loader: stimulus queues expected writes, a
// negedge monitor pops and compares them and tracks the done pulse.
`timescale 1ns/1ps
module tb_regfile_loader;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned FA = 1;
  localparam int unsigned LA = 15;

  logic          clk      = 1'b0;
  logic          reset_n  = 1'b1;
  logic          start    = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          in_ready, busy, done, we3;
  logic [AW-1:0] WA3;
  logic [DW-1:0] WD3;

`ifdef REGFILE_LOADER_VERIFY_EN
  logic [AW-1:0] RA_chk;
  logic [DW-1:0] RD_chk;
  logic          err;
  logic [DW-1:0] rf [16];
  logic          corrupt = 1'b0;

  // Register-file model; optionally corrupts address 9 on write.
  always @(posedge clk)
    if (we3) rf[WA3] <= (corrupt && WA3 == AW'(9)) ? 8'hFF : WD3;
  assign RD_chk = rf[RA_chk];
`endif

  always #5 clk = ~clk;

  regfile_loader #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .FIRST_ADDR (FA),
    .LAST_ADDR  (LA)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .we3      (we3),
    .WA3      (WA3),
    .WD3      (WD3)
`ifdef REGFILE_LOADER_VERIFY_EN
    ,
    .RA_chk   (RA_chk),
    .RD_chk   (RD_chk),
    .err      (err)
`endif
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  int            n_chk  = 0;
  int            n_pass = 0;
  logic [AW-1:0] exp_addr = AW'(FA);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every write must match the head of the scoreboard; done must
  // coincide with the last write (or follow it by one cycle with verify on).
  initial begin : monitor
    exp_t e;
    logic prev_last, cur_last, exp_done;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      cur_last = 1'b0;
      if (we3) begin
        if (sb.size() == 0) check("unexpected_we3", we3, 0);
        else begin
          e = sb.pop_front();
          check("WA3", WA3, e.addr);
          check("WD3", WD3, e.data);
          cur_last = e.last;
        end
      end
`ifdef REGFILE_LOADER_VERIFY_EN
      exp_done = prev_last;
`else
      exp_done = cur_last;
`endif
      if (done || exp_done) check("done", done, exp_done);
      prev_last = cur_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_addr = AW'(FA);
  endtask

  task automatic send(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    #3;
    check("in_ready_load", in_ready, 1);
    sb.push_back('{addr: exp_addr, data: d, last: (exp_addr == AW'(LA))});
    if (exp_addr != AW'(LA)) exp_addr = exp_addr + AW'(1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 6) begin
      tick();
      n++;
    end
    check("done_reached", done, 1);
  endtask

  task automatic run_full(input int unsigned gap_at);
    kick();
    check("busy_after_start", busy, 1);
`ifdef REGFILE_LOADER_VERIFY_EN
    check("err_cleared_on_start", err, 0);
`endif
    for (int unsigned i = 1; i <= 15; i++) begin
      send(DW'(i));
      if (i == gap_at) begin
        for (int unsigned g = 0; g < 3; g++) begin
          start = (g == 0);
          tick();
          start = 1'b0;
          check("we3_gap", we3, 0);
          check("busy_gap", busy, 1);
        end
      end
    end
    wait_done();
    // start in the FINISH cycle must not relaunch
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_finish", busy, 0);
    check("in_ready_after_finish", in_ready, 0);
`ifdef REGFILE_LOADER_VERIFY_EN
    check("err_after_seq", err, corrupt);
`endif
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    #1 reset_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we3", we3, 0);
    check("rst_WA3", WA3, 0);
    check("rst_WD3", WD3, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // in_valid in IDLE is ignored
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) begin
      tick();
      check("in_ready_idle", in_ready, 0);
      check("busy_idle", busy, 0);
    end
    in_valid = 1'b0;

    run_full(0);
    run_full(4);   // back-to-back start, with a 3-cycle gap after address 4

    // Reset mid-LOAD right after the write of address 7
    kick();
    for (int unsigned i = 1; i <= 7; i++) send(DW'(i));
    in_valid = 1'b1;
    in_data  = 8'h08;
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_we3", we3, 0);
    check("mid_rst_WA3", WA3, 0);
    check("mid_rst_WD3", WD3, 0);
    repeat (2) tick();
    in_valid = 1'b0;
    reset_n  = 1'b1;
    repeat (2) begin
      tick();
      check("post_rst_busy", busy, 0);
      check("post_rst_we3", we3, 0);
    end

`ifdef REGFILE_LOADER_VERIFY_EN
    corrupt = 1'b1;
    run_full(0);
    check("err_sticky_idle", err, 1);
    corrupt = 1'b0;
`endif
    run_full(0);

    repeat (3) tick();
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_loader.md
REGFILE_LOADER -- requirements
Module: regfile_loader

Interface
REQ-001 Parameter DATA_W, default 8, width of each register word.
REQ-002 Parameter ADDR_W, default 4, width of the register-file address.
REQ-003 Parameter FIRST_ADDR, default 1, first register written; register 0 is hardwired zero and is never written.
REQ-004 Parameter LAST_ADDR, default 15, last register written.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  request a full load sequence.
REQ-008 in_valid  input  1  source has a word on in_data.
REQ-009 in_data  input  DATA_W  word to write.
REQ-010 in_ready  output  1  loader accepts a word this cycle.
REQ-011 busy  output  1  load sequence in progress.
REQ-012 done  output  1  one-cycle pulse at the end of a sequence.
REQ-013 we3  output  1  register-file write enable.
REQ-014 WA3  output  ADDR_W  register-file write address.
REQ-015 WD3  output  DATA_W  register-file write data.

Function
REQ-016 The FSM SHALL have three states: IDLE, LOAD and FINISH.
- IDLE -> LOAD on start = 1.
- LOAD -> FINISH on the accept of the word for LAST_ADDR.
- FINISH -> IDLE unconditionally after one cycle.
REQ-017 On entry to LOAD, the address counter SHALL be set to FIRST_ADDR.
REQ-018 in_ready SHALL be 1 exactly while the state is LOAD.
REQ-019 An accept is in_valid & in_ready; in_valid while not in LOAD SHALL be ignored.
REQ-020 On each accept, in the next cycle the block SHALL drive we3 = 1, WA3 = current address and WD3 = in_data, all registered.
REQ-021 On each accept, the address SHALL increment by one.
REQ-022 Throughput SHALL be one word per cycle; an in_valid gap of any length SHALL stall without a write.
REQ-023 we3 SHALL be 0 in every cycle not following an accept.
REQ-024 busy SHALL be 1 in LOAD and FINISH.
REQ-025 done SHALL be 1 only in FINISH, which is the same cycle as the write of LAST_ADDR.
REQ-026 start while busy SHALL be ignored.
REQ-027 start in the FINISH cycle SHALL also be ignored.
REQ-028 The address SHALL never exceed LAST_ADDR and SHALL never wrap to 0.
REQ-029 When FIRST_ADDR = LAST_ADDR, the sequence SHALL be exactly one write.

Reset
REQ-030 reset_n = 0 SHALL immediately force the state to IDLE and the address to FIRST_ADDR.
REQ-031 reset_n = 0 SHALL immediately force in_ready, busy, done, we3, WA3 and WD3 to 0, including mid-LOAD.
REQ-032 A reset mid-LOAD SHALL abort the sequence with no partial write after reset release.
REQ-033 The first sequence after reset release SHALL require a new start.

Configuration
REQ-034 Macro REGFILE_LOADER_VERIFY_EN, when defined, SHALL add the ports RA_chk (output, ADDR_W), RD_chk (input, DATA_W) and err (output, 1).
REQ-035 With the macro defined, in the cycle after each write, RA_chk SHALL equal the just-written address, and RD_chk SHALL be compared with the held WD3.
REQ-036 With the macro defined, a mismatch SHALL set err, which is sticky until the next accepted start or reset.
REQ-037 With the macro defined, the FSM SHALL add one state, CHECK, between the final write and FINISH, so done is delayed by one cycle.
REQ-038 Without the macro, none of RA_chk, RD_chk, err or CHECK SHALL exist, and the timing SHALL be as in REQ-016 to REQ-029.

Structure
REQ-039 Package regfile_loader_pkg SHALL hold the state encoding constants and the DATA_W, ADDR_W, FIRST_ADDR and LAST_ADDR defaults.
REQ-040 One sub-module, loader_addr_counter, SHALL implement the load/increment address counter with async active-low reset.

Verification
REQ-041 Reset, then start, then 15 consecutive words 0x01..0x0F -> writes to WA3 = 1..15 with WD3 = 0x01..0x0F on 15 consecutive cycles, and done on the write of address 15.
REQ-042 in_valid deasserted for 3 cycles after the word for address 4 -> we3 = 0 for 3 cycles, and the next write is address 5 with no skipped address.
REQ-043 start pulsed while busy, and in_valid pulsed in IDLE -> no restart, no write, and in_ready stays 0 in IDLE.
REQ-044 reset_n driven low after the word for address 7 -> outputs are 0 immediately, no further writes, and a new start begins at address 1.
REQ-045 With the verify macro, the regfile model corrupts address 9 (reads 0xFF instead of 0x09) -> err = 1 from the check cycle onward, done is one cycle later than without the macro, and err clears on the next start.
REQ-046 Back-to-back sequences (start in the cycle after FINISH) -> the second sequence writes addresses 1..15 again.
